// File: rtl/core_pkg.sv
// Shared constants for the data-memory responder: region decode, MMIO map
// and CTRL register bit layout.
package core_pkg;

  // Address bit that splits RAM (0) from memory-mapped registers (1)
  localparam int REGION_BIT = 11;

  // Word-aligned MMIO register offsets within the data address space
  localparam logic [REGION_BIT:0] MMIO_CYCLE   = 12'h800;
  localparam logic [REGION_BIT:0] MMIO_TIMECMP = 12'h804;
  localparam logic [REGION_BIT:0] MMIO_CTRL    = 12'h808;
  localparam logic [REGION_BIT:0] MMIO_SCRATCH = 12'h80C;

  // CTRL register bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_PEND_BIT = 1;

  // Region captured alongside the read address; NONE only right after reset
  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_RAM  = 2'd1,
    REGION_MMIO = 2'd2
  } region_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous-read RAM. Read-first: a write and read of the
// same word in one cycle returns the previous contents. No reset on the array
// or the read register, so contents survive a core reset.
module dmem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_WORDS  = 512,
  parameter int IDX_WIDTH  = $clog2(RAM_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [IDX_WIDTH-1:0]  i_idx,
  input  logic [DATA_WIDTH-1:0] i_wrdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [RAM_WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Read the old word and commit the optional write on the same edge
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wrdata;
    end
    r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core MEM stage: word RAM below 0x800 and a
// small MMIO block (free-running cycle counter, compare timer, control and
// scratch registers) above it. Reads are issued every cycle and return one
// cycle later.
module dmem_responder
  import core_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int DATA_MEM_ADDR_WIDTH = 12,
  parameter int RAM_WORDS           = 512
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [DATA_MEM_ADDR_WIDTH-1:0] i_addr_mem,
  input  logic [DATA_WIDTH-1:0]          i_wrdata_mem,
  input  logic                           i_we_mem,
  output logic [DATA_WIDTH-1:0]          o_rdata_mem,
  output logic                           o_timer_irq
);

  localparam int RAM_IDX_W = $clog2(RAM_WORDS);
  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  // Byte-lane bits are not used: every access is a full word
  logic                  w_unusedLanes;
  logic                  w_isMmio;
  logic [REGION_BIT:0]   w_regAddr;
  logic [RAM_IDX_W-1:0]  w_ramIdx;
  logic                  w_ramWe;
  logic                  w_regWe;
  logic                  w_hit;
  logic                  w_pendClr;
  logic [DATA_WIDTH-1:0] w_ramRdata;
  logic [DATA_WIDTH-1:0] w_mmioRdata;

  logic [DATA_WIDTH-1:0] r_cycle;
  logic [DATA_WIDTH-1:0] r_timecmp;
  logic [DATA_WIDTH-1:0] r_scratch;
  logic                  r_en;
  logic                  r_pend;
  logic [DATA_WIDTH-1:0] r_mmioRdata;
  region_e               r_regionSel;

  assign w_unusedLanes = ^i_addr_mem[1:0];
  assign w_isMmio      = i_addr_mem[REGION_BIT];
  assign w_regAddr     = {i_addr_mem[REGION_BIT:2], 2'b00};
  assign w_ramIdx      = i_addr_mem[RAM_IDX_W+1:2];
  assign w_ramWe       = i_we_mem & ~w_isMmio;
  assign w_regWe       = i_we_mem & w_isMmio;

  // Compare uses the counter value of this cycle, before it increments
  assign w_hit     = r_en & (r_cycle == r_timecmp);
  assign w_pendClr = w_regWe & (w_regAddr == MMIO_CTRL) & i_wrdata_mem[CTRL_PEND_BIT];

  dmem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .RAM_WORDS  (RAM_WORDS),
    .IDX_WIDTH  (RAM_IDX_W)
  ) u_ram (
    .i_clk    (i_clk),
    .i_we     (w_ramWe),
    .i_idx    (w_ramIdx),
    .i_wrdata (i_wrdata_mem),
    .o_rdata  (w_ramRdata)
  );

  // Select the current (pre-write) value of the addressed MMIO register
  always_comb begin
    w_mmioRdata = '0;
    case (w_regAddr)
      MMIO_CYCLE:   w_mmioRdata = r_cycle;
      MMIO_TIMECMP: w_mmioRdata = r_timecmp;
      MMIO_CTRL: begin
        w_mmioRdata[CTRL_EN_BIT]   = r_en;
        w_mmioRdata[CTRL_PEND_BIT] = r_pend;
      end
      MMIO_SCRATCH: w_mmioRdata = r_scratch;
      default:      w_mmioRdata = '0;
    endcase
  end

  // Counter, timer and MMIO register updates; a compare hit wins over W1C
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle   <= '0;
      r_timecmp <= '0;
      r_scratch <= '0;
      r_en      <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      r_cycle <= r_cycle + ONE;
      r_pend  <= w_hit | (r_pend & ~w_pendClr);
      if (w_regWe) begin
        case (w_regAddr)
          MMIO_TIMECMP: r_timecmp <= i_wrdata_mem;
          MMIO_CTRL:    r_en      <= i_wrdata_mem[CTRL_EN_BIT];
          MMIO_SCRATCH: r_scratch <= i_wrdata_mem;
          default:      ;
        endcase
      end
    end
  end

  // Capture region and MMIO read data so next cycle's mux matches this address
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_regionSel <= REGION_NONE;
      r_mmioRdata <= '0;
    end else begin
      r_regionSel <= w_isMmio ? REGION_MMIO : REGION_RAM;
      r_mmioRdata <= w_mmioRdata;
    end
  end

  // Return path mux; drives zero until the first post-reset read lands
  always_comb begin
    o_rdata_mem = '0;
    case (r_regionSel)
      REGION_RAM:  o_rdata_mem = w_ramRdata;
      REGION_MMIO: o_rdata_mem = r_mmioRdata;
      default:     o_rdata_mem = '0;
    endcase
  end

  assign o_timer_irq = r_pend & r_en;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: scoreboard of expected read data,
// cycle model for CYCLE/timer timing, reset behaviour checks.
module tb_dmem_responder;

  logic        i_clk;
  logic        i_rst_n;
  logic [11:0] i_addr_mem;
  logic [31:0] i_wrdata_mem;
  logic        i_we_mem;
  logic [31:0] o_rdata_mem;
  logic        o_timer_irq;

  typedef struct {
    string       tag;
    logic [31:0] data;
  } sbEntry_t;

  sbEntry_t    sbQueue[$];
  int          compareCount;
  int          mismatchCount;
  logic [31:0] modelCycle;
  logic [31:0] target;

  dmem_responder #(
    .DATA_WIDTH          (32),
    .DATA_MEM_ADDR_WIDTH (12),
    .RAM_WORDS           (512)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_addr_mem   (i_addr_mem),
    .i_wrdata_mem (i_wrdata_mem),
    .i_we_mem     (i_we_mem),
    .o_rdata_mem  (o_rdata_mem),
    .o_timer_irq  (o_timer_irq)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One bus cycle: drive inputs, optionally queue the expected read data,
  // then compare the returned word after the edge
  task automatic applyStimulus(input logic [11:0] addr, input logic we,
                               input logic [31:0] wdata, input bit chk,
                               input logic [31:0] expData, input string tag);
    sbEntry_t e;
    if (chk) begin
      e.tag  = tag;
      e.data = expData;
      sbQueue.push_back(e);
    end
    i_addr_mem   = addr;
    i_we_mem     = we;
    i_wrdata_mem = wdata;
    @(posedge i_clk);
    modelCycle = modelCycle + 32'd1;
    #1;
    i_we_mem = 1'b0;
    if (chk) begin
      if (sbQueue.size() == 0) begin
        checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        e = sbQueue.pop_front();
        checkOutput(e.tag, o_rdata_mem, e.data);
      end
    end
  endtask

  task automatic idle();
    applyStimulus(12'h000, 1'b0, 32'h0, 1'b0, 32'h0, "idle");
  endtask

  task automatic releaseReset();
    @(posedge i_clk);
    #1;
    i_rst_n    = 1'b1;
    modelCycle = 32'd0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    modelCycle    = 32'd0;
    i_rst_n       = 1'b0;
    i_addr_mem    = 12'h0;
    i_wrdata_mem  = 32'h0;
    i_we_mem      = 1'b0;

    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset_rdata", o_rdata_mem, 32'h0);
    checkOutput("reset_irq", {31'h0, o_timer_irq}, 32'h0);
    releaseReset();
    checkOutput("first_cycle_rdata", o_rdata_mem, 32'h0);

    // CYCLE captured at the tenth edge holds the nine completed cycles
    repeat (9) idle();
    applyStimulus(12'h800, 1'b0, 32'h0, 1'b1, modelCycle, "cycle_edge10");
    applyStimulus(12'h800, 1'b1, 32'h55, 1'b0, 32'h0, "cycle_wr");
    applyStimulus(12'h800, 1'b0, 32'h0, 1'b1, modelCycle, "cycle_after_wr");

    // RAM write then read back one cycle later
    applyStimulus(12'h010, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, "ram_wr");
    applyStimulus(12'h010, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, "ram_rd_010");

    // Read-first on a RAM word
    applyStimulus(12'h020, 1'b1, 32'h0000AAAA, 1'b0, 32'h0, "ram_wr_020");
    applyStimulus(12'h020, 1'b1, 32'h00001234, 1'b1, 32'h0000AAAA, "ram_rmw_old");
    applyStimulus(12'h020, 1'b0, 32'h0, 1'b1, 32'h00001234, "ram_rmw_new");

    // Several words, byte-lane bits ignored on both write and read
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(12'(12'h100 + i * 4 + (i % 4)), 1'b1, 32'h01010101 * i,
                    1'b0, 32'h0, "ram_fill");
    end
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(12'(12'h100 + i * 4 + ((i + 1) % 4)), 1'b0, 32'h0,
                    1'b1, 32'h01010101 * i, $sformatf("ram_word%0d", i));
    end
    applyStimulus(12'h010, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, "ram_010_kept");

    // Scratch, read-first on MMIO, and unmapped MMIO offset
    applyStimulus(12'h80C, 1'b1, 32'h00000077, 1'b0, 32'h0, "scr_wr");
    applyStimulus(12'h80C, 1'b1, 32'h00000099, 1'b1, 32'h00000077, "scr_rmw_old");
    applyStimulus(12'h80C, 1'b0, 32'h0, 1'b1, 32'h00000099, "scr_rmw_new");
    applyStimulus(12'h810, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0, "unmapped_wr");
    applyStimulus(12'h810, 1'b0, 32'h0, 1'b1, 32'h0, "unmapped_rd");

    // Fresh reset for the timer scenario
    i_rst_n = 1'b0;
    releaseReset();
    applyStimulus(12'h804, 1'b1, 32'd20, 1'b0, 32'h0, "tcmp_wr");
    applyStimulus(12'h808, 1'b1, 32'h1, 1'b0, 32'h0, "ctrl_en");
    applyStimulus(12'h804, 1'b0, 32'h0, 1'b1, 32'd20, "tcmp_rd");
    for (int k = 0; k < 100 && modelCycle != 32'd20; k++) idle();
    checkOutput("irq_before_hit", {31'h0, o_timer_irq}, 32'h0);
    idle();
    checkOutput("irq_after_hit", {31'h0, o_timer_irq}, 32'h1);
    applyStimulus(12'h808, 1'b0, 32'h0, 1'b1, 32'h3, "ctrl_pend");
    applyStimulus(12'h808, 1'b1, 32'h3, 1'b0, 32'h0, "ctrl_w1c");
    checkOutput("irq_cleared", {31'h0, o_timer_irq}, 32'h0);
    applyStimulus(12'h808, 1'b0, 32'h0, 1'b1, 32'h1, "ctrl_after_w1c");

    // W1C landing in the exact compare-hit cycle loses to the set
    target = modelCycle + 32'd4;
    applyStimulus(12'h804, 1'b1, target, 1'b0, 32'h0, "tcmp_wr2");
    for (int k = 0; k < 100 && modelCycle != target; k++) idle();
    applyStimulus(12'h808, 1'b1, 32'h3, 1'b0, 32'h0, "w1c_on_hit");
    checkOutput("irq_w1c_on_hit", {31'h0, o_timer_irq}, 32'h1);
    applyStimulus(12'h808, 1'b0, 32'h0, 1'b1, 32'h3, "ctrl_pend_kept");

    // Clearing EN keeps PEND and masks the interrupt
    applyStimulus(12'h808, 1'b1, 32'h0, 1'b0, 32'h0, "ctrl_dis");
    checkOutput("irq_masked", {31'h0, o_timer_irq}, 32'h0);
    applyStimulus(12'h808, 1'b0, 32'h0, 1'b1, 32'h2, "ctrl_pend_only");
    applyStimulus(12'h808, 1'b1, 32'h1, 1'b0, 32'h0, "ctrl_reen");
    checkOutput("irq_reassert", {31'h0, o_timer_irq}, 32'h1);

    // Reset asserted with a read in flight
    applyStimulus(12'h040, 1'b1, 32'h0000CAFE, 1'b0, 32'h0, "ram_wr_040");
    applyStimulus(12'h80C, 1'b1, 32'h00000077, 1'b0, 32'h0, "scr_wr77");
    applyStimulus(12'h80C, 1'b0, 32'h0, 1'b1, 32'h00000077, "scr_rd77");
    i_addr_mem = 12'h80C;
    #1;
    i_rst_n = 1'b0;
    #1;
    checkOutput("midread_rst_rdata", o_rdata_mem, 32'h0);
    checkOutput("midread_rst_irq", {31'h0, o_timer_irq}, 32'h0);
    releaseReset();
    checkOutput("post_rst_rdata", o_rdata_mem, 32'h0);
    applyStimulus(12'h80C, 1'b0, 32'h0, 1'b1, 32'h0, "scr_after_rst");
    applyStimulus(12'h040, 1'b0, 32'h0, 1'b1, 32'h0000CAFE, "ram_kept_040");
    applyStimulus(12'h010, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, "ram_kept_010");
    applyStimulus(12'h808, 1'b0, 32'h0, 1'b1, 32'h0, "ctrl_after_rst");

    checkOutput("sb_drain", 32'(sbQueue.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter DATA_MEM_ADDR_WIDTH, default 12, byte-address width of the data port.
REQ-003 SHALL have parameter RAM_WORDS, default 512, number of RAM words.
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_addr_mem  input  DATA_MEM_ADDR_WIDTH  byte address from the core MEM stage.
REQ-007 SHALL have port i_wrdata_mem  input  DATA_WIDTH  store data.
REQ-008 SHALL have port i_we_mem  input  1  store strobe, one word per asserted cycle.
REQ-009 SHALL have port o_rdata_mem  output  DATA_WIDTH  registered read data.
REQ-010 SHALL have port o_timer_irq  output  1  level timer interrupt.

Function
REQ-011 SHALL ignore i_addr_mem[1:0]; all accesses are full 32-bit words.
REQ-012 SHALL decode i_addr_mem[11]=0 as RAM; word index = i_addr_mem[10:2].
REQ-013 SHALL decode i_addr_mem[11]=1 as MMIO: 0x800 CYCLE (RO), 0x804 TIMECMP (RW), 0x808 CTRL (RW), 0x80C SCRATCH (RW); other MMIO offsets read 0, writes ignored.
REQ-014 SHALL perform a read every cycle (no read enable); o_rdata_mem in cycle N+1 reflects the address presented in cycle N.
REQ-015 SHALL register the region select with the address so the cycle-N+1 output mux uses cycle-N decode.
REQ-016 SHALL be read-first: a read and write to the same RAM word or MMIO register in one cycle returns the old value; the new value is visible from the next access.
REQ-017 SHALL commit writes on the edge ending the cycle i_we_mem=1; no write when i_we_mem=0.
REQ-018 SHALL increment CYCLE by 1 every cycle, wrapping 0xFFFF_FFFF -> 0; writes to CYCLE are ignored.
REQ-019 SHALL define CTRL bit0 = EN (RW), bit1 = PEND (set by hardware, write-1-to-clear), bits 31:2 read 0.
REQ-020 SHALL set PEND in the cycle after CYCLE == TIMECMP while EN=1; comparison uses the pre-increment CYCLE value.
REQ-021 SHALL give set priority over clear when a PEND W1C write coincides with a compare hit.
REQ-022 SHALL drive o_timer_irq = PEND & EN, registered-state only (no combinational path from inputs).
REQ-023 SHALL retain PEND when EN is cleared; o_timer_irq drops, and reasserts if EN is set again.
REQ-024 SHALL not alter RAM contents on reset; RAM contents after power-up are undefined.

Reset
REQ-025 SHALL, with i_rst_n=0, asynchronously clear o_rdata_mem, CYCLE, TIMECMP, CTRL, SCRATCH and the registered region select to 0; o_timer_irq=0.
REQ-026 SHALL abandon any in-flight read on reset assertion; the first post-reset cycle outputs 0.
REQ-027 SHALL start CYCLE counting at 0 on the first rising edge after i_rst_n deasserts.

Structure
REQ-028 SHALL place region-select bit position, MMIO offsets (CYCLE/TIMECMP/CTRL/SCRATCH) and CTRL bit indices in core_pkg.
REQ-029 SHALL instantiate one sub-module dmem_ram: single-port, read-first, synchronous-read RAM of RAM_WORDS x DATA_WIDTH, no reset.
REQ-030 SHALL implement the MMIO register file, timer and output mux in dmem_responder itself.

Verification
REQ-031 SHALL cover: write 0xDEADBEEF to 0x010, read 0x010 next cycle -> o_rdata_mem=0xDEADBEEF one cycle after address.
REQ-032 SHALL cover: same-cycle write 0x1234 and read of 0x020 holding 0xAAAA -> output 0xAAAA, following read -> 0x1234.
REQ-033 SHALL cover: reset release, read CYCLE at edge 10 -> value equals elapsed cycles; write 0x55 to CYCLE -> ignored, counting continues.
REQ-034 SHALL cover: TIMECMP=20, CTRL=1 -> o_timer_irq=1 the cycle after CYCLE==20; write CTRL=0x3 -> PEND cleared, irq=0.
REQ-035 SHALL cover: W1C on PEND in the exact compare-hit cycle -> PEND remains 1.
REQ-036 SHALL cover: i_rst_n pulsed low mid-read with SCRATCH=0x77 -> o_rdata_mem=0 immediately, SCRATCH reads 0 afterwards, RAM data preserved.
